// File: rtl/systolic_ctrl_2x2.sv
// systolic_ctrl_2x2: loads A/B operands, streams them into a 2x2 systolic array and captures the results
module systolic_ctrl_2x2 #(
  parameter int WIDTH        = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               wr_mat,
  input  logic [1:0]         wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               arr_clr,
  output logic [WIDTH-1:0]   arr_a_data,
  output logic [WIDTH-1:0]   arr_b_data,
  output logic [1:0]         arr_a_row_idx,
  output logic [1:0]         arr_b_col_idx,
  output logic               arr_valid,
  input  logic [2*WIDTH-1:0] arr_c00,
  input  logic [2*WIDTH-1:0] arr_c01,
  input  logic [2*WIDTH-1:0] arr_c10,
  input  logic [2*WIDTH-1:0] arr_c11,
  input  logic [1:0]         res_sel,
  output logic [2*WIDTH-1:0] res_data
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPTURE} state_t;
  state_t state, nxt;
  logic [1:0] beat, nb;
  logic [3:0] cnt;
  logic [WIDTH-1:0] a_reg [4];
  logic [WIDTH-1:0] b_reg [4];
  logic [2*WIDTH-1:0] result [4];
  logic feed_nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CLEAR : IDLE;
      CLEAR:   nxt = FEED;
      FEED:    nxt = (beat == 2'd3) ? DRAIN : FEED;
      DRAIN:   nxt = (cnt == 4'(DRAIN_CYCLES - 1)) ? CAPTURE : DRAIN;
      CAPTURE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state, so nb is the beat about to be presented.
  assign nb       = (state == FEED) ? beat + 2'd1 : 2'd0;
  assign feed_nxt = (nxt == FEED);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      beat          <= '0;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      arr_clr       <= 1'b1;
      arr_valid     <= 1'b0;
      arr_a_data    <= '0;
      arr_b_data    <= '0;
      arr_a_row_idx <= '0;
      arr_b_col_idx <= '0;
      a_reg         <= '{default: '0};
      b_reg         <= '{default: '0};
      result        <= '{default: '0};
    end else begin
      state         <= nxt;
      beat          <= (state == FEED) ? beat + 2'd1 : 2'd0;
      cnt           <= (state == DRAIN) ? cnt + 4'd1 : 4'd0;
      busy          <= nxt inside {CLEAR, FEED, DRAIN};
      done          <= nxt == CAPTURE;
      arr_clr       <= nxt == CLEAR;
      arr_valid     <= feed_nxt;
      arr_a_data    <= feed_nxt ? a_reg[{nb[0], nb[1]}] : '0;
      arr_b_data    <= feed_nxt ? b_reg[{nb[1], nb[0]}] : '0;
      arr_a_row_idx <= feed_nxt ? {1'b0, nb[0]} : 2'd0;
      arr_b_col_idx <= feed_nxt ? {1'b0, nb[0]} : 2'd0;
      if (state == IDLE && wr_en && !wr_mat) a_reg[wr_addr] <= wr_data;
      if (state == IDLE && wr_en && wr_mat) b_reg[wr_addr] <= wr_data;
      if (nxt == CAPTURE) result <= '{arr_c00, arr_c01, arr_c10, arr_c11};
    end
  end
  assign res_data = result[res_sel];
endmodule

// File: tb/tb_systolic_ctrl_2x2.sv
// tb_systolic_ctrl_2x2: directed bench with a behavioural 2x2 matmul array behind the sequencer
module tb_systolic_ctrl_2x2;
  logic clk = 0, rst = 0, wr_en = 0, wr_mat = 0, start = 0;
  logic [1:0] wr_addr = 0, res_sel = 0;
  logic [7:0] wr_data = 0;
  logic busy, done, arr_clr, arr_valid;
  logic [7:0] arr_a_data, arr_b_data;
  logic [1:0] arr_a_row_idx, arr_b_col_idx;
  logic [15:0] arr_c00, arr_c01, arr_c10, arr_c11, res_data;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  systolic_ctrl_2x2 #(.WIDTH(8), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_mat(wr_mat), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .busy(busy), .done(done), .arr_clr(arr_clr),
    .arr_a_data(arr_a_data), .arr_b_data(arr_b_data),
    .arr_a_row_idx(arr_a_row_idx), .arr_b_col_idx(arr_b_col_idx), .arr_valid(arr_valid),
    .arr_c00(arr_c00), .arr_c01(arr_c01), .arr_c10(arr_c10), .arr_c11(arr_c11),
    .res_sel(res_sel), .res_data(res_data)
  );
  // Array model: latches A[i][k] / B[k][j] per beat, k taken from its own beat count.
  logic [7:0] am [4];
  logic [7:0] bm [4];
  logic [1:0] mn;
  always @(posedge clk) begin
    if (arr_clr) begin
      am <= '{default: '0};
      bm <= '{default: '0};
      mn <= 0;
    end else if (arr_valid) begin
      am[{arr_a_row_idx[0], mn[1]}] <= arr_a_data;
      bm[{mn[1], arr_b_col_idx[0]}] <= arr_b_data;
      mn <= mn + 2'd1;
    end
  end
  always_comb begin
    arr_c00 = 16'(am[0] * bm[0]) + 16'(am[1] * bm[2]);
    arr_c01 = 16'(am[0] * bm[1]) + 16'(am[1] * bm[3]);
    arr_c10 = 16'(am[2] * bm[0]) + 16'(am[3] * bm[2]);
    arr_c11 = 16'(am[2] * bm[1]) + 16'(am[3] * bm[3]);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < 8; i++) begin
      wr_en = 1;
      wr_mat = i[2];
      wr_addr = i[1:0];
      wr_data = i[2] ? bv[31-8*i[1:0] -: 8] : av[31-8*i[1:0] -: 8];
      tick();
    end
    wr_en = 0;
  endtask
  task automatic check_res(input string tag, input logic [63:0] rv);
    for (int s = 0; s < 4; s++) begin
      res_sel = s[1:0];
      #1;
      check($sformatf("%s_res%0d", tag, s), res_data, rv[63-16*s -: 16]);
    end
  endtask
  // Starts an operation in the current cycle and returns in the done cycle (or after a timeout).
  task automatic op(input bit feed_chk, input bit gate);
    logic [7:0] ea [4] = '{1, 3, 2, 4};
    logic [7:0] eb [4] = '{5, 6, 7, 8};
    logic [1:0] ei [4] = '{0, 1, 0, 1};
    int c = 1, dc = 0;
    start = 1;
    tick();
    start = 0;
    while (dc == 0 && c <= 20) begin
      if (c == 1) begin
        check("clear_pulse", arr_clr, 1);
        check("busy_clear", busy, 1);
      end
      if (feed_chk && c >= 2 && c <= 5) begin
        check($sformatf("beat%0d_valid", c-2), arr_valid, 1);
        check($sformatf("beat%0d_clr", c-2), arr_clr, 0);
        check($sformatf("beat%0d_a", c-2), arr_a_data, ea[c-2]);
        check($sformatf("beat%0d_row", c-2), arr_a_row_idx, ei[c-2]);
        check($sformatf("beat%0d_b", c-2), arr_b_data, eb[c-2]);
        check($sformatf("beat%0d_col", c-2), arr_b_col_idx, ei[c-2]);
      end
      if (c == 6) check("drain_valid", arr_valid, 0);
      if (gate && c == 3) begin
        wr_en = 1; wr_mat = 0; wr_addr = 0; wr_data = 9; start = 1;
      end
      if (gate && c == 4) begin
        wr_en = 0; start = 0;
      end
      if (done) dc = c;
      else begin
        tick();
        c++;
      end
    end
    check("done_latency", dc, 10);
    check("busy_at_done", busy, 0);
  endtask
  initial begin
    int n;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", arr_valid, 0);
    check("rst_clr", arr_clr, 1);
    check_res("rst", 64'h0);
    rst = 1;
    tick();
    check("idle_clr", arr_clr, 0);
    load(32'h01020304, 32'h05060708);
    op(1, 0);
    check_res("basic", {16'd19, 16'd22, 16'd43, 16'd50});
    tick();
    check("done_one_cycle", done, 0);
    op(0, 1);
    n = 0;
    repeat (15) begin
      tick();
      if (done) n++;
    end
    check("gate_no_second_done", n, 0);
    check_res("gate", {16'd19, 16'd22, 16'd43, 16'd50});
    load(32'h01020304, 32'h01000001);
    op(0, 0);
    check_res("ident", {16'd1, 16'd2, 16'd3, 16'd4});
    start = 1;
    tick();
    op(0, 0);
    check_res("b2b", {16'd1, 16'd2, 16'd3, 16'd4});
    tick();
    start = 1;
    tick();
    start = 0;
    repeat (6) tick();
    check("mid_in_drain", busy, 1);
    #2 rst = 0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_valid", arr_valid, 0);
    check("mid_clr", arr_clr, 1);
    check_res("mid", 64'h0);
    n = 0;
    repeat (4) begin
      tick();
      if (done) n++;
    end
    check("mid_no_done", n, 0);
    rst = 1;
    tick();
    load(32'h01020304, 32'h05060708);
    op(0, 0);
    check_res("after_rst", {16'd19, 16'd22, 16'd43, 16'd50});
    tick();
    load(32'hFFFFFFFF, 32'hFFFFFFFF);
    op(0, 0);
    check_res("wide", {16'd64514, 16'd64514, 16'd64514, 16'd64514});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
